// File: rtl/display_glyph_decoder.sv
// Display-bus readback: maps LED glyph codes to nibbles and assembles 2- or 4-digit frames.
// Optional idle-gap abort inside a frame is enabled by defining DSPDEC_TIMEOUT_EN.
module display_glyph_decoder #(
  parameter int TIMEOUT = 255
) (
  input  logic        relogio,
  input  logic        reset,
  input  logic [7:0]  glyph_in,
  input  logic        glyph_vld,
  input  logic        frame_sof,
  input  logic        wide,
  input  logic        neg,
  output logic [15:0] valor,
  output logic        valor_neg,
  output logic        valor_vld,
  output logic        erro,
  output logic        ocupado
);

  typedef enum logic [2:0] {S_IDLE, S_D3, S_D2, S_D1, S_D0} state_t;

  state_t      state_q, state_d;
  logic [15:0] shadow_q, shadow_d;
  logic        neg_q, neg_d;
  logic [15:0] valor_q, valor_d;
  logic        valor_neg_q, valor_neg_d;
  logic        valor_vld_q, valor_vld_d;
  logic        erro_q, erro_d;

`ifdef DSPDEC_TIMEOUT_EN
  localparam int GW = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;
  logic [GW-1:0] gap_q, gap_d;
`endif

  logic [3:0] digit;
  logic       glyph_ok;
  logic [3:0] nibble;
  logic       neg_sel;
  logic       active;

  always_comb begin
    glyph_ok = 1'b1;
    digit    = 4'h0;
    case (glyph_in)
      8'h00: digit = 4'h0;
      8'h38: digit = 4'h1;
      8'h7C: digit = 4'h2;
      8'h4F: digit = 4'h3;
      8'h3C: digit = 4'h4;
      8'h5E: digit = 4'h5;
      8'h7B: digit = 4'h6;
      8'h73: digit = 4'h7;
      8'h7F: digit = 4'h8;
      8'h23: digit = 4'h9;
      8'h7E: digit = 4'hA;
      8'h76: digit = 4'hB;
      8'h53: digit = 4'hC;
      8'h67: digit = 4'hD;
      8'h6D: digit = 4'hE;
      8'h03: digit = 4'hF;
      default: glyph_ok = 1'b0;
    endcase
  end

  // A sof glyph is decoded with the incoming sign, later glyphs with the latched one.
  assign neg_sel = frame_sof ? neg : neg_q;
  assign nibble  = neg_sel ? (4'd0 - digit) : digit;
  assign active  = (state_q != S_IDLE);

  // NOTE: every signal assigned here gets a default first so no latch is inferred.
  always_comb begin
    state_d     = state_q;
    shadow_d    = shadow_q;
    neg_d       = neg_q;
    valor_d     = valor_q;
    valor_neg_d = valor_neg_q;
    valor_vld_d = 1'b0;
    erro_d      = erro_q;
`ifdef DSPDEC_TIMEOUT_EN
    gap_d       = gap_q;
`endif

    if (glyph_vld && frame_sof) begin
      if (!glyph_ok) begin
        erro_d  = 1'b1;
        state_d = S_IDLE;
      end else begin
        erro_d = 1'b0;
        neg_d  = neg;
`ifdef DSPDEC_TIMEOUT_EN
        gap_d  = '0;
`endif
        if (wide) begin
          shadow_d = {nibble, 12'h000};
          state_d  = S_D2;
        end else begin
          shadow_d = {8'h00, nibble, 4'h0};
          state_d  = S_D0;
        end
      end
    end else if (glyph_vld && active) begin
      if (!glyph_ok) begin
        erro_d  = 1'b1;
        state_d = S_IDLE;
      end else begin
`ifdef DSPDEC_TIMEOUT_EN
        gap_d = '0;
`endif
        case (state_q)
          S_D3: begin
            shadow_d[15:12] = nibble;
            state_d         = S_D2;
          end
          S_D2: begin
            shadow_d[11:8] = nibble;
            state_d        = S_D1;
          end
          S_D1: begin
            shadow_d[7:4] = nibble;
            state_d       = S_D0;
          end
          S_D0: begin
            // Completion cycle behaves as idle so a sof can follow with no bubble.
            shadow_d[3:0] = nibble;
            valor_d       = {shadow_q[15:4], nibble};
            valor_neg_d   = neg_q;
            valor_vld_d   = 1'b1;
            state_d       = S_IDLE;
          end
          default: state_d = S_IDLE;
        endcase
      end
    end
`ifdef DSPDEC_TIMEOUT_EN
    else if (active) begin
      gap_d = gap_q + 1'b1;
      if (gap_d == GW'(TIMEOUT)) begin
        erro_d  = 1'b1;
        state_d = S_IDLE;
      end
    end
`endif
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge relogio or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      shadow_q    <= '0;
      neg_q       <= 1'b0;
      valor_q     <= '0;
      valor_neg_q <= 1'b0;
      valor_vld_q <= 1'b0;
      erro_q      <= 1'b0;
`ifdef DSPDEC_TIMEOUT_EN
      gap_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      shadow_q    <= shadow_d;
      neg_q       <= neg_d;
      valor_q     <= valor_d;
      valor_neg_q <= valor_neg_d;
      valor_vld_q <= valor_vld_d;
      erro_q      <= erro_d;
`ifdef DSPDEC_TIMEOUT_EN
      gap_q       <= gap_d;
`endif
    end
  end

  assign valor     = valor_q;
  assign valor_neg = valor_neg_q;
  assign valor_vld = valor_vld_q;
  assign erro      = erro_q;
  assign ocupado   = active;

endmodule

// File: tb/tb_display_glyph_decoder.sv
// Self-checking bench for display_glyph_decoder: directed scenarios plus randomized traffic
// compared each cycle against a digit-list frame model.
module tb_display_glyph_decoder;

  localparam int TO = 4;

  typedef struct packed {
    logic       v;
    logic       s;
    logic       w;
    logic       n;
    logic [7:0] g;
  } stim_t;

  logic        relogio = 1'b0;
  logic        reset   = 1'b0;
  logic [7:0]  glyph_in  = 8'h00;
  logic        glyph_vld = 1'b0;
  logic        frame_sof = 1'b0;
  logic        wide      = 1'b0;
  logic        neg       = 1'b0;
  logic [15:0] valor;
  logic        valor_neg;
  logic        valor_vld;
  logic        erro;
  logic        ocupado;

  int n_vec  = 0;
  int n_miss = 0;

  logic [7:0] glyph_tab [16] = '{8'h00, 8'h38, 8'h7C, 8'h4F, 8'h3C, 8'h5E, 8'h7B, 8'h73,
                                 8'h7F, 8'h23, 8'h7E, 8'h76, 8'h53, 8'h67, 8'h6D, 8'h03};

  // Reference model state: a frame is just a list of collected digit values.
  logic [15:0] m_valor;
  logic        m_neg_out;
  logic        m_vld;
  logic        m_erro;
  logic        m_active;
  logic        m_negl;
  int          m_need;
  int          m_gap;
  int          m_digits [$];

  always #5 relogio = ~relogio;

  display_glyph_decoder #(.TIMEOUT(TO)) dut (
    .relogio   (relogio),
    .reset     (reset),
    .glyph_in  (glyph_in),
    .glyph_vld (glyph_vld),
    .frame_sof (frame_sof),
    .wide      (wide),
    .neg       (neg),
    .valor     (valor),
    .valor_neg (valor_neg),
    .valor_vld (valor_vld),
    .erro      (erro),
    .ocupado   (ocupado)
  );

  function automatic bit lookup(input logic [7:0] g, output int d);
    d = 0;
    for (int i = 0; i < 16; i++)
      if (glyph_tab[i] == g) begin
        d = i;
        return 1'b1;
      end
    return 1'b0;
  endfunction

  function automatic int signed_digit(input int d, input logic n);
    return n ? (16 - d) % 16 : d;
  endfunction

  function void model_reset();
    m_valor = 16'h0; m_neg_out = 1'b0; m_vld = 1'b0; m_erro = 1'b0;
    m_active = 1'b0; m_negl = 1'b0; m_need = 0; m_gap = 0;
    m_digits.delete();
  endfunction

  function void model_step();
    int d;
    bit ok;
    int v;
    m_vld = 1'b0;
    if (glyph_vld) begin
      ok = lookup(glyph_in, d);
      if (frame_sof) begin
        if (!ok) begin
          m_erro = 1'b1; m_active = 1'b0;
        end else begin
          m_erro = 1'b0; m_active = 1'b1; m_negl = neg; m_gap = 0;
          m_need = wide ? 4 : 2;
          m_digits.delete();
          m_digits.push_back(signed_digit(d, neg));
        end
      end else if (m_active) begin
        if (!ok) begin
          m_erro = 1'b1; m_active = 1'b0;
        end else begin
          m_gap = 0;
          m_digits.push_back(signed_digit(d, m_negl));
          if (m_digits.size() == m_need) begin
            v = 0;
            foreach (m_digits[i]) v = v * 16 + m_digits[i];
            m_valor = 16'(v); m_neg_out = m_negl; m_vld = 1'b1; m_active = 1'b0;
          end
        end
      end
    end
`ifdef DSPDEC_TIMEOUT_EN
    else if (m_active) begin
      m_gap++;
      if (m_gap == TO) begin
        m_erro = 1'b1; m_active = 1'b0;
      end
    end
`endif
  endfunction

  function automatic logic [19:0] exp_bus();
    return {m_valor, m_neg_out, m_vld, m_erro, m_active};
  endfunction

  function automatic logic [19:0] got_bus();
    return {valor, valor_neg, valor_vld, erro, ocupado};
  endfunction

  task automatic tick(input stim_t st);
    glyph_vld = st.v; frame_sof = st.s; wide = st.w; neg = st.n; glyph_in = st.g;
    @(posedge relogio);
    model_step();
    #1;
  endtask

  task automatic test_reset_init();
    #2;
    model_reset();
    n_vec++;
    if (got_bus() !== 20'h0) begin
      n_miss++;
      $display("FAIL reset_init got %h expected %h", got_bus(), 20'h0);
    end
    #4 reset = 1'b1;
  endtask

  task automatic test_wide_basic();
    stim_t seq [5] = '{'{1,1,1,0,8'h38}, '{1,0,1,0,8'h7C}, '{1,0,1,0,8'h4F},
                       '{1,0,1,0,8'h3C}, '{0,0,0,0,8'h00}};
    int occ = 0;
    for (int i = 0; i < 5; i++) begin
      tick(seq[i]);
      n_vec++;
      if (got_bus() !== exp_bus()) begin
        n_miss++;
        $display("FAIL wide_basic cyc %0d got %h expected %h", i, got_bus(), exp_bus());
      end
      if (ocupado) occ++;
      if (i == 3) begin
        n_vec++;
        if ({valor, valor_neg, valor_vld} !== {16'h1234, 1'b0, 1'b1}) begin
          n_miss++;
          $display("FAIL wide_value got %h/%b/%b expected 1234/0/1", valor, valor_neg, valor_vld);
        end
      end
    end
    n_vec++;
    if (occ !== 3) begin
      n_miss++;
      $display("FAIL wide_ocupado_cycles got %0d expected 3", occ);
    end
  endtask

  task automatic test_narrow_neg();
    stim_t seq [5] = '{'{1,1,0,1,8'h38}, '{0,0,0,0,8'h00}, '{0,0,0,0,8'h00},
                       '{1,0,0,0,8'h03}, '{0,0,0,0,8'h00}};
    int pulses = 0;
    for (int i = 0; i < 5; i++) begin
      tick(seq[i]);
      n_vec++;
      if (got_bus() !== exp_bus()) begin
        n_miss++;
        $display("FAIL narrow_neg cyc %0d got %h expected %h", i, got_bus(), exp_bus());
      end
      if (valor_vld) pulses++;
    end
    n_vec++;
    if ({valor, valor_neg} !== {16'h00F1, 1'b1} || pulses !== 1) begin
      n_miss++;
      $display("FAIL narrow_value got %h/%b pulses %0d expected 00f1/1 pulses 1", valor, valor_neg, pulses);
    end
  endtask

  task automatic test_bad_glyph();
    stim_t seq [4] = '{'{1,1,1,0,8'h38}, '{1,0,1,0,8'h55}, '{1,1,0,0,8'h38}, '{1,0,0,0,8'h7C}};
    for (int i = 0; i < 4; i++) begin
      tick(seq[i]);
      n_vec++;
      if (got_bus() !== exp_bus()) begin
        n_miss++;
        $display("FAIL bad_glyph cyc %0d got %h expected %h", i, got_bus(), exp_bus());
      end
      if (i == 1) begin
        n_vec++;
        if ({erro, valor_vld, ocupado, valor} !== {1'b1, 1'b0, 1'b0, 16'h00F1}) begin
          n_miss++;
          $display("FAIL bad_glyph_abort got erro=%b vld=%b ocu=%b valor=%h expected 1/0/0/00f1",
                   erro, valor_vld, ocupado, valor);
        end
      end
      if (i == 2) begin
        n_vec++;
        if (erro !== 1'b0) begin
          n_miss++;
          $display("FAIL bad_glyph_clear got erro=%b expected 0", erro);
        end
      end
    end
  endtask

  task automatic test_restart();
    stim_t seq [5] = '{'{1,1,1,0,8'h38}, '{1,0,1,0,8'h7C}, '{1,1,0,0,8'h7F},
                       '{1,0,0,0,8'h00}, '{0,0,0,0,8'h00}};
    int pulses = 0;
    for (int i = 0; i < 5; i++) begin
      tick(seq[i]);
      n_vec++;
      if (got_bus() !== exp_bus()) begin
        n_miss++;
        $display("FAIL restart cyc %0d got %h expected %h", i, got_bus(), exp_bus());
      end
      if (valor_vld) pulses++;
    end
    n_vec++;
    if ({valor, erro} !== {16'h0080, 1'b0} || pulses !== 1) begin
      n_miss++;
      $display("FAIL restart_value got %h erro=%b pulses %0d expected 0080/0 pulses 1", valor, erro, pulses);
    end
  endtask

  task automatic test_back_to_back();
    stim_t seq [5] = '{'{1,1,0,0,8'h38}, '{1,0,0,0,8'h7C}, '{1,1,0,0,8'h4F},
                       '{1,0,0,0,8'h3C}, '{0,0,0,0,8'h00}};
    int pulses = 0;
    for (int i = 0; i < 5; i++) begin
      tick(seq[i]);
      n_vec++;
      if (got_bus() !== exp_bus()) begin
        n_miss++;
        $display("FAIL back_to_back cyc %0d got %h expected %h", i, got_bus(), exp_bus());
      end
      if (valor_vld) pulses++;
    end
    n_vec++;
    if (valor !== 16'h0034 || pulses !== 2) begin
      n_miss++;
      $display("FAIL back_to_back_value got %h pulses %0d expected 0034 pulses 2", valor, pulses);
    end
  endtask

  task automatic test_reset_mid();
    stim_t seq [3] = '{'{1,1,1,0,8'h38}, '{1,0,1,0,8'h7C}, '{1,0,1,0,8'h4F}};
    for (int i = 0; i < 3; i++) tick(seq[i]);
    #2 reset = 1'b0;
    #1;
    model_reset();
    n_vec++;
    if (got_bus() !== 20'h0) begin
      n_miss++;
      $display("FAIL reset_mid got %h expected %h", got_bus(), 20'h0);
    end
    #2 reset = 1'b1;
    tick('{1,0,1,0,8'h3C});
    n_vec++;
    if (got_bus() !== exp_bus() || got_bus() !== 20'h0) begin
      n_miss++;
      $display("FAIL reset_stray_glyph got %h expected %h", got_bus(), 20'h0);
    end
  endtask

  task automatic test_timeout();
    tick('{1,1,0,0,8'h38});
    for (int i = 0; i < TO; i++) begin
      tick('{0,0,0,0,8'h00});
      n_vec++;
      if (got_bus() !== exp_bus()) begin
        n_miss++;
        $display("FAIL timeout cyc %0d got %h expected %h", i, got_bus(), exp_bus());
      end
    end
    n_vec++;
`ifdef DSPDEC_TIMEOUT_EN
    if ({erro, ocupado, valor_vld} !== 3'b100) begin
      n_miss++;
      $display("FAIL timeout_abort got erro=%b ocu=%b vld=%b expected 1/0/0", erro, ocupado, valor_vld);
    end
`else
    if ({erro, ocupado, valor_vld} !== 3'b010) begin
      n_miss++;
      $display("FAIL timeout_wait got erro=%b ocu=%b vld=%b expected 0/1/0", erro, ocupado, valor_vld);
    end
`endif
  endtask

  task automatic test_random();
    stim_t st;
    for (int i = 0; i < 3000; i++) begin
      st.v = ($urandom_range(0, 9) < 6);
      st.s = ($urandom_range(0, 9) < 2);
      st.w = 1'($urandom);
      st.n = 1'($urandom);
      st.g = ($urandom_range(0, 9) < 9) ? glyph_tab[$urandom_range(0, 15)] : 8'($urandom);
      tick(st);
      n_vec++;
      if (got_bus() !== exp_bus()) begin
        n_miss++;
        $display("FAIL random cyc %0d got %h expected %h", i, got_bus(), exp_bus());
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset_init();
    test_wide_basic();
    test_narrow_neg();
    test_bad_glyph();
    test_restart();
    test_back_to_back();
    test_reset_mid();
    test_timeout();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
